// File: rtl/skip_add32_seq.sv
// Byte-serial adder: one 8-bit carry-skip adder is reused once per byte,
// least significant byte first, behind valid/ready handshakes on both sides.

module skip_adder8 (
  output logic [7:0] s,
  output logic       co,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci
);
  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [4:0] w_c_lo;
  logic [4:0] w_c_hi;
  logic       w_blk0_co;

  function automatic logic [4:0] ripple4(input logic [3:0] g, input logic [3:0] p, input logic c);
    logic [4:0] r;
    r[0] = c;
    for (int i = 0; i < 4; i++) r[i+1] = g[i] | (p[i] & r[i]);
    return r;
  endfunction

  assign w_p = a ^ b;
  assign w_g = a & b;

  // A nibble whose bits all propagate passes its carry-in straight through.
  assign w_c_lo    = ripple4(w_g[3:0], w_p[3:0], ci);
  assign w_blk0_co = (&w_p[3:0]) ? ci : w_c_lo[4];
  assign w_c_hi    = ripple4(w_g[7:4], w_p[7:4], w_blk0_co);
  assign co        = (&w_p[7:4]) ? w_blk0_co : w_c_hi[4];
  assign s         = w_p ^ {w_c_hi[3:0], w_c_lo[3:0]};
endmodule

module skip_add32_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  co
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       w_s;
  logic             w_co;
  logic [IDX_W+2:0] w_bit;

  assign w_bit = {r_idx, 3'b000};

  skip_adder8 u_add (
    .s  (w_s),
    .co (w_co),
    .a  (r_a[w_bit +: 8]),
    .b  (r_b[w_bit +: 8]),
    .ci (r_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_idx == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Untouched sum bytes keep their old contents until overwritten in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ci;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_bit +: 8] <= w_s;
          r_carry           <= w_co;
          r_idx             <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum = r_sum;
  assign co  = r_carry;
endmodule

// File: doc/skip_add32_seq.md
SKIP_ADD32_SEQ -- requirements
Module: skip_add32_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the requester presents an operand set.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 The block SHALL have port a, input, 8*NBYTES bits: operand A.
REQ-007 The block SHALL have port b, input, 8*NBYTES bits: operand B.
REQ-008 The block SHALL have port ci, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum and co are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, 8*NBYTES bits: the registered result.
REQ-012 The block SHALL have port co, output, 1 bit: the registered carry-out.

Function
REQ-013 The block SHALL instantiate exactly one skip_adder8 (port order s, co, a, b, ci) and SHALL time-share it byte-serially, least significant byte first.
REQ-014 The block SHALL implement a three-state FSM:
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after byte NBYTES-1 is processed.
- DONE -> IDLE on out_valid && out_ready.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 On accept, the block SHALL capture a, b into operand registers, load ci into the carry register and clear the byte index to 0.
- Input changes after accept SHALL be ignored.
REQ-017 In RUN, each cycle the block SHALL feed byte[idx] of the captured a and b plus the carry register into the adder.
- It SHALL write the adder's s into sum byte[idx] and the adder's co into the carry register.
- It SHALL increment idx, using an idx counter of width clog2(NBYTES).
REQ-018 The block SHALL assert out_valid exactly NBYTES cycles after the accept edge.
- At that point co SHALL equal the final carry register value and sum SHALL hold the full result.
REQ-019 The result SHALL be mod 2^(8*NBYTES).
- Overflow SHALL wrap, with the carry reported only on co.
REQ-020 In DONE, sum, co and out_valid SHALL hold stable until out_ready is sampled high.
REQ-021 An in_valid asserted during RUN or DONE SHALL NOT be accepted; there is no accept in the same cycle as result handoff.
- Minimum request-to-request period is NBYTES + 2 cycles with out_ready held high.
REQ-022 In RUN, sum bytes not yet written SHALL retain their previous values; sum is only guaranteed while out_valid = 1.

Reset
REQ-023 While rst = 1 at a clock edge, the block SHALL enter IDLE with the following values:
- in_ready = 1, out_valid = 0, sum = 0, co = 0.
- idx = 0, carry register = 0, operand registers = 0.
REQ-024 Reset SHALL take priority over all other events, including in_valid or out_ready in the same cycle.
REQ-025 A reset during RUN or DONE SHALL abort the operation with no out_valid pulse, and the block SHALL accept a new request in the first cycle after rst deasserts.

Verification
REQ-026 The bench SHALL cover: NBYTES=4, a=5, b=10, ci=1, out_ready=1 -> out_valid 4 cycles after accept, sum=16, co=0; then a=10, b=33, ci=0 -> sum=43, co=0.
REQ-027 The bench SHALL cover: a=0x000000FF, b=0x00000001, ci=0 -> sum=0x00000100, co=0, showing a carry crossing a byte boundary.
REQ-028 The bench SHALL cover: a=0xFFFFFFFF, b=0x00000000, ci=1 -> sum=0x00000000, co=1, showing wrap-around through all bytes.
REQ-029 The bench SHALL cover: result ready while out_ready is held low for 3 cycles -> out_valid, sum and co stable for all 3 cycles, in_ready=0 throughout, with in_valid held high and not accepted.
REQ-030 The bench SHALL cover: rst=1 for 1 cycle at the 2nd RUN cycle of a=0x12345678, b=0x11111111 -> no out_valid, all outputs at reset values; the next request a=1, b=2, ci=0 -> sum=3, co=0.
REQ-031 The bench SHALL cover: a random regression of at least 1000 operand sets with random out_ready backpressure, with every {co,sum} equal to a+b+ci on 8*NBYTES+1 bits.
